// File: rtl/systolic_pkg.sv
// Shared constants, FSM state type and enable-window helper for the systolic sequencer.
package systolic_pkg;

  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned FRAC_WIDTH = 8;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StFeed,
    StDrain,
    StDone
  } seq_state_e;

  // Cycles the PE array must stay enabled so the last operand pair reaches PE[N-1][N-1].
  function automatic int unsigned calc_enable_len(input int unsigned k_len,
                                                  input int unsigned n,
                                                  input int unsigned pe_lat);
    return k_len + 2 * (n - 1) * pe_lat + 1;
  endfunction

endpackage

// File: rtl/systolic_skew_line.sv
// Delay line of Depth+1 registers (capture register plus Depth skew stages) with sync clear.
module systolic_skew_line
  import systolic_pkg::*;
#(
  parameter int unsigned Depth = 0,
  parameter int unsigned Width = DATA_WIDTH
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] stage_q [Depth+1];

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      for (int unsigned i = 0; i <= Depth; i++) begin
        stage_q[i] <= '0;
      end
    end else if (en_i) begin
      stage_q[0] <= d_i;
      for (int unsigned i = 1; i <= Depth; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[Depth];

endmodule

// File: rtl/systolic_sequencer.sv
// Operand sequencer for an N x N output-stationary PE array: clear, feed with diagonal skew, drain.
// Optional busy-cycle counter output perf_cycles when SYSTOLIC_SEQ_PERF_CNT_EN is defined.
module systolic_sequencer #(
  parameter  int unsigned N          = 4,
  parameter  int unsigned DATA_WIDTH = systolic_pkg::DATA_WIDTH,
  parameter  int unsigned K_MAX      = 16,
  parameter  int unsigned PE_LAT     = 1,
  localparam int unsigned KW         = $clog2(K_MAX + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [KW-1:0]           k_len,
  output logic                    busy,
  output logic                    done,
  output logic                    rd_en,
  output logic [KW-1:0]           rd_addr,
  input  logic [N*DATA_WIDTH-1:0] a_col_data,
  input  logic [N*DATA_WIDTH-1:0] b_row_data,
  output logic [N*DATA_WIDTH-1:0] a_stage,
  output logic [N*DATA_WIDTH-1:0] b_stage,
  output logic                    pe_enable,
  output logic                    pe_clear
`ifdef SYSTOLIC_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]             perf_cycles
`endif
);

  import systolic_pkg::*;

  // The job counter runs from the first FEED cycle up to the last pe_enable cycle.
  localparam int unsigned CntMax = K_MAX + 2 * (N - 1) * PE_LAT + 2;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  seq_state_e      state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            vld_q;
  logic [CntW-1:0] k_ext;
  logic [CntW-1:0] en_len;
  logic            in_window;

  assign k_ext  = CntW'(k_q);
  assign en_len = CntW'(calc_enable_len(32'(k_q), N, PE_LAT));

  // Lane 0 first shows A[0][0] two cycles after the first read: one buffer cycle, one capture.
  assign in_window = (cnt_q >= CntW'(2)) && (cnt_q <= en_len + CntW'(1));

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    cnt_d     = cnt_q;
    busy      = 1'b1;
    done      = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = '0;
    pe_clear  = 1'b0;
    pe_enable = 1'b0;
    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (start) begin
          k_d     = (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;
          cnt_d   = '0;
          state_d = StClear;
        end
      end
      StClear: begin
        pe_clear = 1'b1;
        cnt_d    = '0;
        state_d  = (k_q == '0) ? StDone : StFeed;
      end
      StFeed: begin
        rd_en     = 1'b1;
        rd_addr   = cnt_q[KW-1:0];
        pe_enable = in_window;
        cnt_d     = cnt_q + CntW'(1);
        if (cnt_q == k_ext - CntW'(1)) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        pe_enable = in_window;
        cnt_d     = cnt_q + CntW'(1);
        if (cnt_q == en_len + CntW'(1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      k_q     <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      vld_q   <= rd_en;
    end
  end

  // Buffer data is only meaningful the cycle after a read; otherwise feed zeros into the skew.
  for (genvar g = 0; g < N; g++) begin : g_lane
    logic [DATA_WIDTH-1:0] a_in;
    logic [DATA_WIDTH-1:0] b_in;

    assign a_in = vld_q ? a_col_data[g*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign b_in = vld_q ? b_row_data[g*DATA_WIDTH +: DATA_WIDTH] : '0;

    systolic_skew_line #(
      .Depth(g),
      .Width(DATA_WIDTH)
    ) u_a_line (
      .clk_i(clk),
      .clr_i(rst),
      .en_i (busy),
      .d_i  (a_in),
      .q_o  (a_stage[g*DATA_WIDTH +: DATA_WIDTH])
    );

    systolic_skew_line #(
      .Depth(g),
      .Width(DATA_WIDTH)
    ) u_b_line (
      .clk_i(clk),
      .clr_i(rst),
      .en_i (busy),
      .d_i  (b_in),
      .q_o  (b_stage[g*DATA_WIDTH +: DATA_WIDTH])
    );
  end

`ifdef SYSTOLIC_SEQ_PERF_CNT_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (state_q == StIdle && start) begin
      perf_d = '0;
    end else if (busy) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_systolic_sequencer.sv
// Directed/random bench for systolic_sequencer against a cycle-indexed model of each job.
module tb_systolic_sequencer;

  localparam int unsigned N    = 4;
  localparam int unsigned DW   = 16;
  localparam int unsigned KMAX = 16;
  localparam int unsigned PL   = 1;
  localparam int unsigned KW   = $clog2(KMAX + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [KW-1:0]   k_len;
  logic            busy;
  logic            done;
  logic            rd_en;
  logic [KW-1:0]   rd_addr;
  logic [N*DW-1:0] a_col_data;
  logic [N*DW-1:0] b_row_data;
  logic [N*DW-1:0] a_stage;
  logic [N*DW-1:0] b_stage;
  logic            pe_enable;
  logic            pe_clear;
`ifdef SYSTOLIC_SEQ_PERF_CNT_EN
  logic [31:0]     perf_cycles;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int last_dc     = 0;

  logic [DW-1:0] a_mem [N][32];
  logic [DW-1:0] b_mem [32][N];

  always #5 clk = ~clk;

  systolic_sequencer #(
    .N         (N),
    .DATA_WIDTH(DW),
    .K_MAX     (KMAX),
    .PE_LAT    (PL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .k_len     (k_len),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .a_col_data(a_col_data),
    .b_row_data(b_row_data),
    .a_stage   (a_stage),
    .b_stage   (b_stage),
    .pe_enable (pe_enable),
    .pe_clear  (pe_clear)
`ifdef SYSTOLIC_SEQ_PERF_CNT_EN
    ,
    .perf_cycles(perf_cycles)
`endif
  );

  // Synchronous operand buffers; garbage on cycles without a read.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      a_col_data[i*DW +: DW] <= rd_en ? a_mem[i][rd_addr] : DW'($urandom);
      b_row_data[i*DW +: DW] <= rd_en ? b_mem[rd_addr][i] : DW'($urandom);
    end
  end

  task automatic chk(input string tag, input int c, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s @cycle %0d: observed %0h, expected %0h", tag, c, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag, input int c);
    chk({tag, "_busy"}, c, 64'(busy), 64'(0));
    chk({tag, "_done"}, c, 64'(done), 64'(0));
    chk({tag, "_rd_en"}, c, 64'(rd_en), 64'(0));
    chk({tag, "_pe_enable"}, c, 64'(pe_enable), 64'(0));
    chk({tag, "_pe_clear"}, c, 64'(pe_clear), 64'(0));
    chk({tag, "_a_stage"}, c, 64'(a_stage), 64'(0));
    chk({tag, "_b_stage"}, c, 64'(b_stage), 64'(0));
  endtask

  // Called at a settled point in an IDLE cycle (cycle 0 of the job); returns in cycle dc+1.
  task automatic run_job(input int kin, input int stray, input int abort_at);
    int k, e, dc, idx;
    logic [63:0] ea, eb;
    k  = (kin > int'(KMAX)) ? int'(KMAX) : kin;
    e  = k + 2 * (int'(N) - 1) * int'(PL) + 1;
    dc = (k == 0) ? 2 : 4 + e;
    for (int i = 0; i < int'(N); i++) begin
      for (int kk = 0; kk < 32; kk++) begin
        a_mem[i][kk] = DW'($urandom);
        b_mem[kk][i] = DW'($urandom);
      end
    end
    start = 1'b1;
    k_len = KW'(kin);
    for (int c = 1; c <= dc + 1; c++) begin
      @(posedge clk);
      #1;
      start = (c == stray);
      ea = '0;
      eb = '0;
      for (int i = 0; i < int'(N); i++) begin
        idx = c - 4 - i;
        if (idx >= 0 && idx < k) begin
          ea[i*DW +: DW] = a_mem[i][idx];
          eb[i*DW +: DW] = b_mem[idx][i];
        end
      end
      chk("busy", c, 64'(busy), 64'(c >= 1 && c <= dc));
      chk("done", c, 64'(done), 64'(c == dc));
      chk("pe_clear", c, 64'(pe_clear), 64'(c == 1));
      chk("rd_en", c, 64'(rd_en), 64'(k > 0 && c >= 2 && c < 2 + k));
      if (k > 0 && c >= 2 && c < 2 + k) chk("rd_addr", c, 64'(rd_addr), 64'(c - 2));
      chk("pe_enable", c, 64'(pe_enable), 64'(k > 0 && c >= 4 && c < 4 + e));
      chk("a_stage", c, 64'(a_stage), ea);
      chk("b_stage", c, 64'(b_stage), eb);
`ifdef SYSTOLIC_SEQ_PERF_CNT_EN
      chk("perf_cycles", c, 64'(perf_cycles), 64'((c <= dc) ? c - 1 : dc));
`endif
      if (c == abort_at) begin
        rst = 1'b1;
        break;
      end
    end
    last_dc = dc;
    if (abort_at > 0) begin
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk_quiet("abort", abort_at + 1);
`ifdef SYSTOLIC_SEQ_PERF_CNT_EN
      chk("abort_perf", abort_at + 1, 64'(perf_cycles), 64'(0));
`endif
      for (int c = 0; c < 6; c++) begin
        @(posedge clk);
        #1;
        chk("post_abort_done", c, 64'(done), 64'(0));
        chk("post_abort_busy", c, 64'(busy), 64'(0));
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    k_len = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_quiet("reset", 0);
`ifdef SYSTOLIC_SEQ_PERF_CNT_EN
    chk("reset_perf", 0, 64'(perf_cycles), 64'(0));
`endif
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_job(4, 3, 0);   // start pulsed mid-FEED must be ignored
    run_job(0, 0, 0);   // back-to-back, empty job
    run_job(1, 0, 0);
    run_job(16, 0, 0);
    run_job(20, 0, 0);  // clamps to K_MAX
    repeat (3) run_job(int'($urandom_range(1, KMAX)), 0, 0);
    @(posedge clk);
    #1;
    run_job(8, 0, 5);   // reset during FEED
    run_job(3, 0, 0);

    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      chk("idle_busy", c, 64'(busy), 64'(0));
      chk("idle_done", c, 64'(done), 64'(0));
`ifdef SYSTOLIC_SEQ_PERF_CNT_EN
      chk("idle_perf", c, 64'(perf_cycles), 64'(last_dc));
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
